// File: rtl/vae_frame_sequencer_if.sv
// Stream, BRAM and autoencoder strobes of the frame sequencer grouped in one bundle.
// master is the sequencer side, slave is the surrounding fabric / testbench side.
interface vae_frame_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              vae_done_m;
  logic              vae_last_m;
  logic              vae_done_s;
  logic              vae_last_s;
  logic [ADDR_W-1:0] res_addr;
  logic              res_we;
  logic              res_en;
  logic              m_ready;
  logic              m_valid;
  logic              m_last;
  logic [ADDR_W-1:0] frame_len;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  s_valid, s_last, vae_done_s, vae_last_s, m_ready,
    output s_ready, in_addr, vae_done_m, vae_last_m, res_addr, res_we, res_en,
           m_valid, m_last, frame_len, busy, err_timeout
  );

  modport slave (
    output s_valid, s_last, vae_done_s, vae_last_s, m_ready,
    input  s_ready, in_addr, vae_done_m, vae_last_m, res_addr, res_we, res_en,
           m_valid, m_last, frame_len, busy, err_timeout
  );
endinterface

// File: rtl/vae_frame_sequencer.sv
// Frame sequencer: load input BRAM, feed the autoencoder, collect results, stream them out.
// Optional DRAIN watchdog enabled by defining SEQ_WATCHDOG_EN.
module vae_frame_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int RES_BASE    = 0,
  parameter int WDOG_CYCLES = 4096
) (
  input logic                   aclk,
  input logic                   areset,
  vae_frame_sequencer_if.master bus
);
  typedef enum logic [1:0] {LOAD, FEED, DRAIN, SEND} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] RES_START = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  state_t            state, next_state;
  logic              s_ready_q, done_m_q, last_m_q, m_valid_q, m_last_q;
  logic [ADDR_W-1:0] in_addr_q, frame_len_q, res_addr_q, k_q, m_cnt_q, rd_cnt_q;
  logic              accept, load_end, feed_end, res_write, drain_end, send_end, wdog_fire;
  logic              can_read, res_we_c, res_en_c, busy_c;

  assign accept    = (state == LOAD) && s_ready_q && bus.s_valid;
  assign load_end  = accept && (bus.s_last || in_addr_q == ADDR_MAX);
  // frame_len of 0 means a full 2^ADDR_W frame, so the last address is frame_len-1 mod 2^ADDR_W
  assign feed_end  = (state == FEED) && (in_addr_q == frame_len_q - ONE);
  assign res_write = (state == DRAIN) && bus.vae_done_s;
  assign drain_end = res_write && bus.vae_last_s;
  assign can_read  = (!m_valid_q || bus.m_ready) && (rd_cnt_q != m_cnt_q);
  assign send_end  = (state == SEND) && m_valid_q && bus.m_ready && m_last_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy_c     = (state != LOAD);
    res_we_c   = res_write;
    res_en_c   = 1'b0;
    case (state)
      LOAD:  if (load_end) next_state = FEED;
      FEED:  if (feed_end) next_state = DRAIN;
      DRAIN: begin
        if (drain_end)      next_state = SEND;
        else if (wdog_fire) next_state = LOAD;
      end
      SEND: begin
        res_en_c = can_read;
        if (send_end) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_ready_q   <= 1'b0;
      done_m_q    <= 1'b0;
      last_m_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      in_addr_q   <= '0;
      frame_len_q <= '0;
      res_addr_q  <= '0;
      k_q         <= '0;
      m_cnt_q     <= '0;
      rd_cnt_q    <= '0;
    end else begin
      s_ready_q <= (next_state == LOAD);
      // BRAM read latency 1: strobes trail the FEED address by one cycle
      done_m_q  <= (state == FEED);
      last_m_q  <= feed_end;
      case (state)
        LOAD: begin
          if (accept) begin
            frame_len_q <= frame_len_q + ONE;
            in_addr_q   <= load_end ? '0 : in_addr_q + ONE;
          end
        end
        FEED: begin
          in_addr_q <= feed_end ? '0 : in_addr_q + ONE;
          if (feed_end) begin
            res_addr_q <= RES_START;
            k_q        <= '0;
          end
        end
        DRAIN: begin
          if (res_write) begin
            k_q        <= k_q + ONE;
            res_addr_q <= drain_end ? RES_START : res_addr_q + ONE;
          end
          if (drain_end) begin
            m_cnt_q  <= k_q + ONE;
            rd_cnt_q <= '0;
          end
          if (wdog_fire) begin
            frame_len_q <= '0;
            res_addr_q  <= '0;
          end
        end
        SEND: begin
          // output stage: the BRAM output register holds the word while m_valid waits
          if (res_en_c) begin
            res_addr_q <= res_addr_q + ONE;
            rd_cnt_q   <= rd_cnt_q + ONE;
            m_valid_q  <= 1'b1;
            m_last_q   <= (rd_cnt_q + ONE == m_cnt_q);
          end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
          end
          if (send_end) begin
            frame_len_q <= '0;
            res_addr_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0] wdog_q;
  logic            err_q;

  assign wdog_fire = (state == DRAIN) && !bus.vae_done_s &&
                     (wdog_q == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != DRAIN || bus.vae_done_s) wdog_q <= '0;
      else                                  wdog_q <= wdog_q + WD_W'(1);
      if (wdog_fire) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign wdog_fire       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.s_ready    = s_ready_q;
  assign bus.in_addr    = in_addr_q;
  assign bus.vae_done_m = done_m_q;
  assign bus.vae_last_m = last_m_q;
  assign bus.res_addr   = res_addr_q;
  assign bus.res_we     = res_we_c;
  assign bus.res_en     = res_en_c;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.busy       = busy_c;
endmodule

// File: tb/tb_vae_frame_sequencer.sv
// Bench for vae_frame_sequencer: frame vectors from a table, a result-BRAM model and a
// scoreboard of result words, plus hand-written reset and watchdog sequences.
module tb_vae_frame_sequencer;
  localparam int AW       = 10;
  localparam int RES_BASE = 5;

  logic aclk = 1'b0;
  logic areset;
  int   n_checks = 0;
  int   n_pass   = 0;

  vae_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  vae_frame_sequencer #(.ADDR_W(AW), .RES_BASE(RES_BASE), .WDOG_CYCLES(16)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  // result BRAM model with one-cycle read latency; output holds while res_en is low
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] bram_q;
  logic [15:0] res_data;
  logic [15:0] sb[$];

  always @(posedge aclk) begin
    if (bus.res_we) mem[bus.res_addr] <= res_data;
    if (bus.res_en) bram_q <= mem[bus.res_addr];
  end

  typedef struct {
    int beats;
    bit use_last;
    int exp_len;
    bit noise;
    int results;
    int gap;
    int stall_at;
    int stall_len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  task automatic load_feed(input int beats, input bit use_last, input int exp_len, input bit noise);
    int bad = 0, fbad = 0, wbad = 0, ndone = 0, nlast = 0, last_at = -1;
    for (int i = 0; i < beats; i++) begin
      @(negedge aclk);
      if (!bus.s_ready || bus.in_addr != AW'(i)) bad++;
      bus.s_valid = 1'b1;
      bus.s_last  = use_last && (i == beats - 1);
    end
    @(negedge aclk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("load_addr", bad, 0);
    check("s_ready_drop", bus.s_ready, 0);
    check("frame_len", bus.frame_len, exp_len);
    check("busy_feed", bus.busy, 1);
    for (int c = 0; c <= beats + 1; c++) begin
      if (c > 0) @(negedge aclk);
      if (noise && c < beats) begin
        bus.s_valid = 1'b1; bus.vae_done_s = 1'b1; bus.vae_last_s = 1'b1;
      end else begin
        bus.s_valid = 1'b0; bus.vae_done_s = 1'b0; bus.vae_last_s = 1'b0;
      end
      #1;
      if (c < beats && bus.in_addr != AW'(c)) fbad++;
      if (c < beats && bus.res_we) wbad++;
      if (bus.vae_done_m) ndone++;
      if (bus.vae_last_m) begin nlast++; last_at = c; end
    end
    check("feed_addr", fbad, 0);
    check("feed_ignore_done_s", wbad, 0);
    check("feed_done_cnt", ndone, beats);
    check("feed_last_cnt", nlast, 1);
    check("feed_last_pos", last_at, beats);
    check("frame_len_hold", bus.frame_len, exp_len);
  endtask

  task automatic drain(input int results, input int gap);
    int abad = 0, wbad = 0;
    for (int r = 0; r < results; r++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge aclk);
        bus.vae_done_s = 1'b0;
        bus.vae_last_s = 1'b0;
        #1;
        if (bus.res_we) wbad++;
      end
      @(negedge aclk);
      bus.vae_done_s = 1'b1;
      bus.vae_last_s = (r == results - 1);
      res_data = 16'($urandom_range(0, 65535));
      sb.push_back(res_data);
      #1;
      if (!bus.res_we || bus.res_addr != AW'(RES_BASE + r)) abad++;
    end
    @(negedge aclk);
    bus.vae_done_s = 1'b0;
    bus.vae_last_s = 1'b0;
    check("drain_addr", abad, 0);
    check("drain_gap_we", wbad, 0);
  endtask

  task automatic send(input int results, input int stall_at, input int stall_len);
    int hs = 0, stall_left = 0, bad_data = 0, bad_last = 0, bad_stall = 0;
    bit got_last = 0, stalled = 0, prev_stall = 0, prev_last = 0;
    logic [15:0] want;
    for (int t = 0; t < 400 && !got_last; t++) begin
      if (t > 0) @(negedge aclk);
      if (!stalled && stall_len > 0 && bus.m_valid && hs == stall_at) begin
        stall_left = stall_len;
        stalled    = 1;
      end
      bus.m_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (t == 0) check("send_first_read", {bus.res_en, bus.m_valid}, 2'b10);
      if (t == 1) check("m_valid_rise", bus.m_valid, 1);
      if (prev_stall && (!bus.m_valid || bus.m_last != prev_last)) bad_stall++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_last  = bus.m_last;
      if (prev_stall && bus.res_en) bad_stall++;
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) bad_data++;
        else begin
          want = sb.pop_front();
          if (bram_q != want) bad_data++;
          if (bus.m_last != (sb.size() == 0)) bad_last++;
        end
        hs++;
        if (bus.m_last) got_last = 1;
      end
    end
    check("send_data", bad_data, 0);
    check("send_last", bad_last, 0);
    check("send_stall", bad_stall, 0);
    check("send_done", got_last, 1);
    check("send_count", hs, results);
    check("sb_empty", sb.size(), 0);
    @(negedge aclk);
    bus.m_ready = 1'b0;
    #1;
    check("s_ready_back", bus.s_ready, 1);
    check("m_valid_clear", {bus.m_valid, bus.m_last}, 0);
    check("frame_len_clear", bus.frame_len, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  task automatic run_frame(input vec_t v);
    load_feed(v.beats, v.use_last, v.exp_len, v.noise);
    drain(v.results, v.gap);
    send(v.results, v.stall_at, v.stall_len);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{beats:4,    use_last:1'b1, exp_len:4, noise:1'b0, results:3, gap:2, stall_at:99, stall_len:0};
    vecs[1] = '{beats:1,    use_last:1'b1, exp_len:1, noise:1'b1, results:1, gap:0, stall_at:99, stall_len:0};
    vecs[2] = '{beats:6,    use_last:1'b1, exp_len:6, noise:1'b1, results:5, gap:0, stall_at:2,  stall_len:5};
    vecs[3] = '{beats:3,    use_last:1'b1, exp_len:3, noise:1'b0, results:4, gap:1, stall_at:1,  stall_len:3};
    vecs[4] = '{beats:1024, use_last:1'b0, exp_len:0, noise:1'b0, results:2, gap:0, stall_at:99, stall_len:0};
    vecs[5] = '{beats:7,    use_last:1'b1, exp_len:7, noise:1'b1, results:6, gap:3, stall_at:0,  stall_len:2};

    areset = 1'b1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.vae_done_s = 1'b0; bus.vae_last_s = 1'b0;
    bus.m_ready = 1'b0;
    res_data = '0;
    repeat (3) @(negedge aclk);
    check("reset_flags", {bus.s_ready, bus.vae_done_m, bus.vae_last_m, bus.res_we, bus.res_en,
                          bus.m_valid, bus.m_last, bus.busy, bus.err_timeout}, 0);
    check("reset_counters", {bus.in_addr, bus.res_addr, bus.frame_len}, 0);
    areset = 1'b0;
    #1;
    check("s_ready_before_edge", bus.s_ready, 0);
    @(posedge aclk);
    #1;
    check("s_ready_first_edge", bus.s_ready, 1);

    for (int v = 0; v < 6; v++) run_frame(vecs[v]);

    // reset in the middle of FEED discards the frame
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      bus.s_valid = 1'b1;
      bus.s_last  = (i == 4);
    end
    @(negedge aclk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(negedge aclk);
    #1;
    check("pre_reset_done_m", bus.vae_done_m, 1);
    #1;
    areset = 1'b1;
    #1;
    check("mid_reset_flags", {bus.s_ready, bus.vae_done_m, bus.vae_last_m, bus.res_we, bus.res_en,
                              bus.m_valid, bus.m_last, bus.busy, bus.err_timeout}, 0);
    check("mid_reset_counters", {bus.in_addr, bus.res_addr, bus.frame_len}, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("release_s_ready_low", bus.s_ready, 0);
    @(posedge aclk);
    #1;
    check("release_s_ready_high", bus.s_ready, 1);
    run_frame('{beats:2, use_last:1'b1, exp_len:2, noise:1'b0, results:2, gap:1, stall_at:99, stall_len:0});

`ifdef SEQ_WATCHDOG_EN
    begin
      int d;
      load_feed(2, 1'b1, 2, 1'b0);
      d = 1;
      while (!bus.err_timeout && d < 100) begin
        @(negedge aclk);
        #1;
        d++;
      end
      check("wdog_cycles", d, 16);
      check("wdog_back_to_load", {bus.s_ready, bus.busy, bus.m_valid}, 3'b100);
      check("wdog_frame_len", bus.frame_len, 0);
      repeat (3) @(negedge aclk);
      #1;
      check("wdog_sticky", bus.err_timeout, 1);
    end
`else
    load_feed(2, 1'b1, 2, 1'b0);
    repeat (40) @(negedge aclk);
    #1;
    check("drain_waits", {bus.err_timeout, bus.busy, bus.res_en, bus.m_valid, bus.s_ready}, 5'b01000);
    drain(1, 0);
    send(1, 99, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
